// File: rtl/data_sram_axi_bridge.sv
// Data-side SRAM-to-AXI4 bridge: turns one memory-stage request into a single-beat
// AXI read or write and stalls the core until the result is held in DONE.
module data_sram_axi_bridge #(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
  input  logic            clk,
  input  logic            rst,
  // core memory-stage side
  input  logic            data_sram_en,
  input  logic [3:0]      data_sram_wen,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic [31:0]     data_sram_rdata,
  output logic            d_stall,
  input  logic            cpu_stall,
  // AXI read address
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  // AXI read data
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI write address
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  // AXI write data
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI write response
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_ok_q, aw_ok_d;
  logic        w_ok_q, w_ok_d;
  logic        aw_done;
  logic        w_done;

  // Response IDs/status are not acted on; only one transaction is ever in flight.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;
  assign araddr  = {addr_q[31:2], 2'b00};
  assign awaddr  = {addr_q[31:2], 2'b00};
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

  assign data_sram_rdata = rdata_q;
  assign d_stall         = data_sram_en & (state_q != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    aw_ok_d = aw_ok_q;
    w_ok_d  = w_ok_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    aw_done = 1'b0;
    w_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_sram_en) begin
          addr_d = data_sram_addr;
          if (|data_sram_wen) begin
            wdata_d = data_sram_wdata;
            wstrb_d = data_sram_wen;
            state_d = WR_REQ;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end

      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          state_d = DONE;
        end
      end

      WR_REQ: begin
        awvalid = ~aw_ok_q;
        wvalid  = ~w_ok_q;
        // A channel counts as done if it completed earlier or handshakes this cycle.
        aw_done = aw_ok_q | awready;
        w_done  = w_ok_q | wready;
        if (aw_done && w_done) begin
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = WR_RESP;
        end else begin
          aw_ok_d = aw_done;
          w_ok_d  = w_done;
        end
      end

      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = DONE;
      end

      DONE: begin
        // Hold the result until the whole pipeline is free to advance.
        if (!cpu_stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: a table of reads/writes against a
// delay-programmable AXI slave, plus stall-hold and async-reset sequences.
module tb_data_sram_axi_bridge;

  logic        clk;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        cpu_stall;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  data_sram_axi_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .d_stall(d_stall), .cpu_stall(cpu_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [31:0] exp_addr;
    int          exp_stall;
  } vec_t;

  vec_t vecs[6];

  int errors = 0;
  int checks = 0;

  // slave configuration (written by the stimulus, read by the slave)
  int          cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
  logic [31:0] cfg_rdata = '0;

  // monitor counters (written only by the slave/monitor process)
  int          ar_hs_cnt = 0, r_hs_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;
  int          ar_cyc_cnt = 0, aw_cyc_cnt = 0, w_cyc_cnt = 0, overlap_cnt = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // AXI slave model with per-channel programmable delays, plus handshake monitor.
  initial begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit rd_pend, aw_got, w_got, b_pend;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
    rid = 4'd1; rresp = 2'b00; rlast = 1'b1; bid = 4'd1; bresp = 2'b00;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (arvalid) ar_cyc_cnt++;
      if (awvalid) aw_cyc_cnt++;
      if (wvalid)  w_cyc_cnt++;
      if (ar_hs) begin ar_hs_cnt++; last_araddr = araddr; end
      if (aw_hs) begin aw_hs_cnt++; last_awaddr = awaddr; end
      if (w_hs)  begin w_hs_cnt++; last_wdata = wdata; last_wstrb = wstrb; end
      if (r_hs)  r_hs_cnt++;
      if (b_hs)  b_hs_cnt++;
      if ((arvalid || rready) && (awvalid || wvalid || bready)) overlap_cnt++;
      @(posedge clk);
      #1;
      if (!rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (r_hs) rvalid = 0;
      if (b_hs) bvalid = 0;
      if (ar_hs) begin rd_pend = 1; r_cnt = 0; end
      if (aw_hs) aw_got = 1;
      if (w_hs)  w_got = 1;
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
      if (rd_pend) begin
        if (r_cnt == cfg_r_dly) begin rvalid = 1; rdata = cfg_rdata; rd_pend = 0; end
        else r_cnt++;
      end
      if (b_pend) begin
        if (b_cnt == cfg_b_dly) begin bvalid = 1; b_pend = 0; end
        else b_cnt++;
      end
      if (arvalid) begin arready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
      else begin arready = 0; ar_cnt = 0; end
      if (awvalid) begin awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
      else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= cfg_w_dly); w_cnt++; end
      else begin wready = 0; w_cnt = 0; end
    end
  end

  // Call at posedge+1 of the request (IDLE) cycle; returns at the DONE-cycle negedge.
  task automatic do_access(input vec_t v, input string tag);
    int ar0, r0, aw0, w0, b0, arc0, awc0, wc0, stall;
    logic [31:0] rd_prev;
    bit done;
    ar0 = ar_hs_cnt; r0 = r_hs_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    arc0 = ar_cyc_cnt; awc0 = aw_cyc_cnt; wc0 = w_cyc_cnt;
    rd_prev = data_sram_rdata;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_aw_dly = v.aw_dly;
    cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly; cfg_rdata = v.rdat;
    data_sram_en    = 1'b1;
    data_sram_wen   = v.is_wr ? v.wen : 4'b0000;
    data_sram_addr  = v.addr;
    data_sram_wdata = v.wdat;
    stall = 0;
    done  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_stall) stall++;
      else begin done = 1; break; end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall), 32'(v.exp_stall));
    if (v.is_wr) begin
      chk({tag, "_aw_hs"}, 32'(aw_hs_cnt - aw0), 32'd1);
      chk({tag, "_w_hs"}, 32'(w_hs_cnt - w0), 32'd1);
      chk({tag, "_b_hs"}, 32'(b_hs_cnt - b0), 32'd1);
      chk({tag, "_ar_hs"}, 32'(ar_hs_cnt - ar0), 32'd0);
      chk({tag, "_awaddr"}, last_awaddr, v.exp_addr);
      chk({tag, "_wdata"}, last_wdata, v.wdat);
      chk({tag, "_wstrb"}, 32'(last_wstrb), 32'(v.wen));
      chk({tag, "_awvalid_cycles"}, 32'(aw_cyc_cnt - awc0), 32'(v.aw_dly + 1));
      chk({tag, "_wvalid_cycles"}, 32'(w_cyc_cnt - wc0), 32'(v.w_dly + 1));
      chk({tag, "_rdata_kept"}, data_sram_rdata, rd_prev);
    end else begin
      chk({tag, "_ar_hs"}, 32'(ar_hs_cnt - ar0), 32'd1);
      chk({tag, "_r_hs"}, 32'(r_hs_cnt - r0), 32'd1);
      chk({tag, "_aw_hs"}, 32'(aw_hs_cnt - aw0), 32'd0);
      chk({tag, "_araddr"}, last_araddr, v.exp_addr);
      chk({tag, "_arvalid_cycles"}, 32'(ar_cyc_cnt - arc0), 32'(v.ar_dly + 1));
      chk({tag, "_rdata"}, data_sram_rdata, v.rdat);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t v;
    int ar_base;
    bit seen;
    //           wr  addr          wen      wdata         rdata         ar r aw w b  exp_addr      stall
    vecs[0] = '{1'b0, 32'h1FC0_0104, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h1FC0_0104, 3};
    vecs[1] = '{1'b1, 32'h8000_0003, 4'b1000, 32'h11223344, 32'h0,        0, 0, 3, 0, 0, 32'h8000_0000, 6};
    vecs[2] = '{1'b1, 32'h0000_0100, 4'b1111, 32'hA5A50F0F, 32'h0,        0, 0, 0, 0, 0, 32'h0000_0100, 3};
    vecs[3] = '{1'b0, 32'h0000_0104, 4'b0000, 32'h0,        32'h0BADF00D, 1, 2, 0, 0, 0, 32'h0000_0104, 6};
    vecs[4] = '{1'b1, 32'h0000_0202, 4'b0011, 32'hCAFEBABE, 32'h0,        0, 0, 0, 2, 1, 32'h0000_0200, 6};
    vecs[5] = '{1'b0, 32'h7FFF_FFFE, 4'b0000, 32'h0,        32'h12345678, 0, 0, 0, 0, 0, 32'h7FFF_FFFC, 3};

    rst = 1'b0;
    cpu_stall = 1'b0;
    data_sram_en = 1'b0;
    data_sram_wen = 4'b0000;
    data_sram_addr = '0;
    data_sram_wdata = '0;
    #12;
    chk("reset_arvalid", 32'(arvalid), 32'd0);
    chk("reset_rready", 32'(rready), 32'd0);
    chk("reset_awvalid", 32'(awvalid), 32'd0);
    chk("reset_wvalid", 32'(wvalid), 32'd0);
    chk("reset_bready", 32'(bready), 32'd0);
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_d_stall_idle", 32'(d_stall), 32'd0);
    chk("const_ar_fields", {arid, arlen, arsize, arburst, 15'd0}, {4'd1, 8'd0, 3'b010, 2'b01, 15'd0});
    chk("const_aw_fields", {awid, awlen, awsize, awburst, wlast, 14'd0}, {4'd1, 8'd0, 3'b010, 2'b01, 1'b1, 14'd0});
    @(negedge clk);
    rst = 1'b1;

    // Table: all accesses issued back-to-back.
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end
    data_sram_en = 1'b0;

    // Read completes while the pipeline is frozen elsewhere; result must be held.
    @(posedge clk); #1;
    cpu_stall = 1'b1;
    v = '{1'b0, 32'h0000_0308, 4'b0000, 32'h0, 32'h5555AAAA, 0, 0, 0, 0, 0, 32'h0000_0308, 3};
    do_access(v, "hold_rd");
    ar_base = ar_hs_cnt;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("hold_c%0d_d_stall", c), 32'(d_stall), 32'd0);
      chk($sformatf("hold_c%0d_rdata", c), data_sram_rdata, 32'h5555AAAA);
      chk($sformatf("hold_c%0d_arvalid", c), 32'(arvalid), 32'd0);
    end
    @(posedge clk); #1;
    cpu_stall = 1'b0;
    @(negedge clk);
    chk("hold_release_d_stall", 32'(d_stall), 32'd0);
    @(posedge clk); #1;
    v = '{1'b0, 32'h0000_030C, 4'b0000, 32'h0, 32'h600DF00D, 0, 0, 0, 0, 0, 32'h0000_030C, 3};
    do_access(v, "after_hold");
    chk("hold_single_ar_total", 32'(ar_hs_cnt - ar_base), 32'd1);
    @(posedge clk); #1;
    data_sram_en = 1'b0;

    // Asynchronous reset while waiting in RD_DATA.
    @(posedge clk); #1;
    cfg_ar_dly = 0; cfg_r_dly = 5; cfg_rdata = 32'hFFFF0000;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h0000_0400;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rready) begin seen = 1; break; end
    end
    chk("areset_reached_rd_data", 32'(seen), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_rready", 32'(rready), 32'd0);
    chk("areset_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
    chk("areset_bready", 32'(bready), 32'd0);
    chk("areset_rdata", data_sram_rdata, 32'h0);
    data_sram_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, 32'h0000_0404, 4'b0000, 32'h0, 32'h0F0F0F0F, 0, 0, 0, 0, 0, 32'h0000_0404, 3};
    do_access(v, "post_reset_rd");
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    repeat (2) @(posedge clk);

    chk("no_channel_overlap", 32'(overlap_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
- Converts the core's data-side SRAM-like request into single-beat AXI4 read or write transactions, and generates the memory-stage stall.
- Sits directly downstream of the core's memory-stage port: data_sram_enM, memwriteM, aluout_pM, writedataM in; readdataM, d_stallM out.
- Handles one outstanding transaction at a time.
- Holds the returned data until the core's pipeline advances, so a request is never issued twice.

Parameters:
- AXI_ID, 4'd1, fixed ARID/AWID value.
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  memory-stage access valid (data_sram_enM).
- data_sram_wen  in  4  byte write enables (memwriteM); nonzero means write.
- data_sram_addr  in  32  physical address (aluout_pM).
- data_sram_wdata  in  32  write data (writedataM).
- data_sram_rdata  out  32  read data (readdataM).
- d_stall  out  1  memory-stage stall to the core.
- cpu_stall  in  1  pipeline frozen by another source (i-fetch or divider).
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  AXI read address channel.
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data channel.
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  AXI write address channel.
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel.
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1  AXI write response channel.
- bready  out  1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all valid/ready outputs 0.
  - data_sram_rdata=0; aw_ok=0, w_ok=0.
- Constant outputs:
  - arlen=awlen=0; arsize=awsize=3'b010; arburst=awburst=2'b01; wlast=1.
  - arid=awid=AXI_ID.
  - araddr = awaddr = {addr[31:2],2'b00}.
  - wdata and wstrb come from registered copies captured at issue.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - If en and wen==0: capture addr, go RD_ADDR.
  - If en and wen!=0: capture addr/wdata/wen, go WR_REQ.
  - Otherwise stay in IDLE.
- RD_ADDR: arvalid=1; on arready go RD_DATA. arvalid stays high until the handshake.
- RD_DATA: rready=1; on rvalid, register rdata into data_sram_rdata and go DONE. rresp and rid are ignored.
- WR_REQ:
  - awvalid=~aw_ok and wvalid=~w_ok.
  - aw_ok and w_ok set on their own handshakes; the two channels complete in either order or together.
  - When both are complete (counting a handshake in the current cycle), go WR_RESP and clear aw_ok and w_ok.
- WR_RESP: bready=1; on bvalid go DONE.
- DONE:
  - If cpu_stall=0: go IDLE.
  - If cpu_stall=1: stay in DONE. data_sram_rdata is held and no new request is issued.
- d_stall (combinational) = data_sram_en & (state!=DONE). It is 1 in IDLE on the request cycle itself.
- Latency:
  - Minimum read, zero-wait slave: request cycle → stall for 3 cycles (IDLE, RD_ADDR, RD_DATA), data valid in DONE cycle 4.
  - Minimum write: IDLE, WR_REQ, WR_RESP, then DONE.
- data_sram_rdata changes only on an rvalid handshake in RD_DATA.
- The core holds its request inputs stable while d_stall=1. The bridge uses the captured copies regardless.
- Back-to-back accesses: DONE→IDLE, and the next memory instruction is seen in IDLE with no bubble beyond the IDLE cycle.
- An asynchronous reset mid-transaction abandons it; all valids drop immediately.

Test Plan:
- Read 0x1FC0_0104, slave arready=1 and rvalid next cycle with rdata=0xDEADBEEF → araddr=0x1FC0_0104, d_stall high for 3 cycles, data_sram_rdata=0xDEADBEEF in DONE, exactly one AR handshake.
- Write addr 0x8000_0003, wen=4'b1000, wdata=0x11223344; wready 3 cycles before awready → awaddr=0x8000_0000, wstrb=4'b1000; wvalid drops after its handshake while awvalid stays high; one B handshake; then DONE.
- Read completes while cpu_stall=1 for 5 cycles → state stays DONE, d_stall=0, rdata stable, no second arvalid; IDLE entered on the cycle after cpu_stall falls.
- Back-to-back write then read to 0x100/0x104 → exactly one AW/W/B then one AR/R, correct order, no overlap.
- Assert rst=0 asynchronously while in RD_DATA with arvalid history → rready and all valids 0 immediately, state IDLE, data_sram_rdata=0.
- AW and W accepted in the same cycle → WR_RESP entered on the next cycle, no duplicate valid.
